// File: rtl/arbitro_de_funcionalidade.sv
// Two-requester function arbiter for a shared LED matrix column and four discrete LEDs.
// Each request is classified by user code, decoded into an 11-bit pattern, and merged by priority.
module arbitro_de_funcionalidade (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] user0,
    input  logic [2:0] func0,
    input  logic [2:0] user1,
    input  logic [2:0] func1,
    output logic [6:0] matriz,
    output logic [3:0] leds,
    output logic       conflito,
    output logic       vencedor
);

    localparam int unsigned PRIO_W = 2;
    localparam int unsigned PAT_W  = 11;
    localparam int unsigned MAT_W  = 7;
    localparam int unsigned LED_W  = 4;

    localparam logic [2:0] USER_ADMIN = 3'b101;
    localparam logic [2:0] USER_USER  = 3'b001;

    localparam logic [PRIO_W-1:0] PRIO_NONE  = 2'd0;
    localparam logic [PRIO_W-1:0] PRIO_USER  = 2'd1;
    localparam logic [PRIO_W-1:0] PRIO_ADMIN = 2'd2;

    // Priority class from the 3-bit user code; unknown codes are neutral.
    function automatic logic [PRIO_W-1:0] f_prio(input logic [2:0] u);
        case (u)
            USER_ADMIN: f_prio = PRIO_ADMIN;
            USER_USER:  f_prio = PRIO_USER;
            default:    f_prio = PRIO_NONE;
        endcase
    endfunction

    // Pattern layout is {matriz[6:0], leds[3:0]}; leds order is {LED6, LED4, LED3, LED1}.
    function automatic logic [PAT_W-1:0] f_decode(input logic [PRIO_W-1:0] p,
                                                  input logic [2:0]        f);
        logic [MAT_W-1:0] mat;
        logic [LED_W-1:0] led;
        mat = '0;
        led = '0;
        if (p == PRIO_ADMIN) begin
            case (f)
                3'd1:    mat = 7'b0000001;
                3'd2:    mat = 7'b0000010;
                3'd3:    mat = 7'b0000100;
                3'd4:    mat = 7'b0001000;
                3'd5:    mat = 7'b0010000;
                3'd6:    mat = 7'b0100000;
                3'd7:    mat = 7'b1000000;
                default: mat = '0;
            endcase
        end else if (p == PRIO_USER) begin
            // Functions 2, 5 and 7 are not permitted for plain users.
            case (f)
                3'd1:    led = 4'b0001;
                3'd3:    led = 4'b0010;
                3'd4:    led = 4'b0100;
                3'd6:    led = 4'b1000;
                default: led = '0;
            endcase
        end
        f_decode = {mat, led};
    endfunction

    logic [PRIO_W-1:0] w_prio0;
    logic [PRIO_W-1:0] w_prio1;
    logic              w_valid0;
    logic              w_valid1;
    logic              w_eq;
    logic              w_conflict;
    logic              w_winner;
    logic [PAT_W-1:0]  w_pat0;
    logic [PAT_W-1:0]  w_pat1;
    logic [PAT_W-1:0]  w_pat_out;

    logic [MAT_W-1:0]  r_matriz;
    logic [LED_W-1:0]  r_leds;
    logic              r_conflito;
    logic              r_vencedor;

    // Classification, decode and combination of both requests.
    always_comb begin
        w_prio0    = f_prio(user0);
        w_prio1    = f_prio(user1);
        w_valid0   = (w_prio0 != PRIO_NONE) && (func0 != 3'd0);
        w_valid1   = (w_prio1 != PRIO_NONE) && (func1 != 3'd0);
        w_eq       = (func0 == func1);
        w_pat0     = w_valid0 ? f_decode(w_prio0, func0) : '0;
        w_pat1     = w_valid1 ? f_decode(w_prio1, func1) : '0;
        w_conflict = w_valid0 && w_valid1 && w_eq;
        // Ties go to requester 0.
        w_winner   = (w_prio1 > w_prio0);
        w_pat_out  = w_pat0 | w_pat1;
        if (w_conflict) begin
            w_pat_out = w_winner ? w_pat1 : w_pat0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_matriz   <= '0;
            r_leds     <= '0;
            r_conflito <= 1'b0;
            r_vencedor <= 1'b0;
        end else begin
            r_matriz   <= w_pat_out[PAT_W-1:LED_W];
            r_leds     <= w_pat_out[LED_W-1:0];
            r_conflito <= w_conflict;
            r_vencedor <= w_conflict & w_winner;
        end
    end

    assign matriz   = r_matriz;
    assign leds     = r_leds;
    assign conflito = r_conflito;
    assign vencedor = r_vencedor;

endmodule

// File: tb/tb_arbitro_de_funcionalidade.sv
// Scoreboard bench for arbitro_de_funcionalidade: directed vectors with hand-computed results.
module tb_arbitro_de_funcionalidade;

    typedef struct packed {
        logic [6:0] m;
        logic [3:0] l;
        logic       c;
        logic       v;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] user0;
    logic [2:0] func0;
    logic [2:0] user1;
    logic [2:0] func1;
    logic [6:0] matriz;
    logic [3:0] leds;
    logic       conflito;
    logic       vencedor;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp;
    int    n_err;

    arbitro_de_funcionalidade dut (
        .clk      (clk),
        .rst      (rst),
        .user0    (user0),
        .func0    (func0),
        .user1    (user1),
        .func1    (func1),
        .matriz   (matriz),
        .leds     (leds),
        .conflito (conflito),
        .vencedor (vencedor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and record what must appear after the next edge.
    task automatic issue(input string nm, input logic r,
                         input logic [2:0] u0, input logic [2:0] f0,
                         input logic [2:0] u1, input logic [2:0] f1,
                         input logic [6:0] em, input logic [3:0] el,
                         input logic ec, input logic ev);
        exp_t e;
        @(negedge clk);
        rst   = r;
        user0 = u0;
        func0 = f0;
        user1 = u1;
        func1 = f1;
        e.m = em;
        e.l = el;
        e.c = ec;
        e.v = ev;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are valid every cycle, checked just after the active edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if ({matriz, leds, conflito, vencedor} !== {e.m, e.l, e.c, e.v}) begin
                n_err++;
                $display("FAIL %s: got matriz=%b leds=%b conflito=%b vencedor=%b, expected matriz=%b leds=%b conflito=%b vencedor=%b",
                         nm, matriz, leds, conflito, vencedor, e.m, e.l, e.c, e.v);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        user0 = 3'b101;
        func0 = 3'b001;
        user1 = 3'b001;
        func1 = 3'b001;

        //     name              rst u0      f0      u1      f1      matriz      leds     c     v
        issue("reset_a",        1, 3'b101, 3'b001, 3'b001, 3'b001, 7'b0000000, 4'b0000, 1'b0, 1'b0);
        issue("reset_b",        1, 3'b101, 3'b001, 3'b001, 3'b001, 7'b0000000, 4'b0000, 1'b0, 1'b0);
        issue("admin_vs_user",  0, 3'b101, 3'b001, 3'b001, 3'b001, 7'b0000001, 4'b0000, 1'b1, 1'b0);
        issue("user_vs_admin",  0, 3'b001, 3'b001, 3'b101, 3'b001, 7'b0000001, 4'b0000, 1'b1, 1'b1);
        issue("diff_funcs",     0, 3'b101, 3'b010, 3'b001, 3'b001, 7'b0000010, 4'b0001, 1'b0, 1'b0);
        issue("neutral_user",   0, 3'b000, 3'b000, 3'b001, 3'b011, 7'b0000000, 4'b0010, 1'b0, 1'b0);
        issue("user_no_perm",   0, 3'b001, 3'b101, 3'b000, 3'b000, 7'b0000000, 4'b0000, 1'b0, 1'b0);
        issue("user_tie",       0, 3'b001, 3'b110, 3'b001, 3'b110, 7'b0000000, 4'b1000, 1'b1, 1'b0);
        issue("invalid_codes",  0, 3'b111, 3'b111, 3'b010, 3'b111, 7'b0000000, 4'b0000, 1'b0, 1'b0);
        issue("noperm_conf0",   0, 3'b101, 3'b101, 3'b001, 3'b101, 7'b0010000, 4'b0000, 1'b1, 1'b0);
        issue("noperm_conf1",   0, 3'b001, 3'b101, 3'b101, 3'b101, 7'b0010000, 4'b0000, 1'b1, 1'b1);
        issue("admin_or",       0, 3'b101, 3'b111, 3'b101, 3'b011, 7'b1000100, 4'b0000, 1'b0, 1'b0);
        issue("admin_tie",      0, 3'b101, 3'b011, 3'b101, 3'b011, 7'b0000100, 4'b0000, 1'b1, 1'b0);
        issue("user_or",        0, 3'b001, 3'b100, 3'b001, 3'b001, 7'b0000000, 4'b0101, 1'b0, 1'b0);
        issue("func1_zero",     0, 3'b001, 3'b001, 3'b101, 3'b000, 7'b0000000, 4'b0001, 1'b0, 1'b0);
        issue("both_func_zero", 0, 3'b001, 3'b000, 3'b001, 3'b000, 7'b0000000, 4'b0000, 1'b0, 1'b0);
        issue("admin_neutral",  0, 3'b101, 3'b110, 3'b000, 3'b110, 7'b0100000, 4'b0000, 1'b0, 1'b0);
        issue("reset_mid",      1, 3'b001, 3'b011, 3'b101, 3'b111, 7'b0000000, 4'b0000, 1'b0, 1'b0);
        issue("after_reset",    0, 3'b001, 3'b011, 3'b101, 3'b111, 7'b1000000, 4'b0010, 1'b0, 1'b0);
        issue("user_led4",      0, 3'b001, 3'b100, 3'b110, 3'b100, 7'b0000000, 4'b0100, 1'b0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
